// File: rtl/sram_pkg.sv
// Shared types and constants for the single-port SRAM controller.
//   sram_state_t : controller FSM states (clearing / serving requests)
//   LANE_W       : bits per byte-enable lane
//   lane_count() : number of byte lanes in a word of the given width
package sram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } sram_state_t;

    localparam int unsigned LANE_W = 8;

    function automatic int unsigned lane_count(input int unsigned width);
        return width / LANE_W;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Storage for the SRAM controller: DATA_W x DEPTH words, no reset.
// Ports:
//   clk_i   : rising-edge clock
//   we_i    : per-lane write enables (one bit per LANE_W bits of data)
//   addr_i  : word address, shared by the write and the read path
//   wdata_i : write data
//   rdata_o : combinational read data; zero for addresses >= DEPTH
module sram_array
    import sram_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 12,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                            clk_i,
    input  logic [lane_count(DATA_W)-1:0]   we_i,
    input  logic [ADDR_W-1:0]               addr_i,
    input  logic [DATA_W-1:0]               wdata_i,
    output logic [DATA_W-1:0]               rdata_o
);

    localparam int unsigned NLANES = lane_count(DATA_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              addr_ok;

    // DEPTH need not be a power of two, so the top of the address space is unbacked.
    assign addr_ok = 32'(addr_i) < DEPTH;

    always_ff @(posedge clk_i) begin
        if (addr_ok) begin
            for (int unsigned l = 0; l < NLANES; l++) begin
                if (we_i[l]) begin
                    mem_q[addr_i][l*LANE_W +: LANE_W] <= wdata_i[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign rdata_o = addr_ok ? mem_q[addr_i] : '0;

endmodule

// File: rtl/sram_sp_ctrl.sv
// Single-port synchronous SRAM controller with valid/ready request port,
// byte-lane writes, RD_LATENCY-cycle registered read data and a hardware
// clear sequencer that writes INIT_VAL to every word after reset or on
// init_start.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   init_start            : pulse to re-run the clear sequence (ignored while clearing)
//   req_valid/req_ready   : request handshake; req_ready is purely registered
//   req_we, req_addr      : write(1)/read(0) and word address
//   req_wdata, req_be     : write data and per-byte enables
//   rsp_valid             : one-cycle read-data pulse
//   rsp_rdata, rsp_err    : read data (held between pulses), out-of-range flag
//   init_busy             : clear sequence running
module sram_sp_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       DEPTH      = 12,
    parameter int unsigned       ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned       RD_LATENCY = 1,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          init_start,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    input  logic [lane_count(DATA_W)-1:0] req_be,
    output logic                          rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    output logic                          init_busy
);

    localparam int unsigned       NLANES = lane_count(DATA_W);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

    sram_state_t       state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              req_ready_q;
    logic              init_busy_q;

    logic              accept;
    logic              rd_accept;
    logic              in_range;
    logic [NLANES-1:0] arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;
    logic [DATA_W-1:0] rd_data_d;

    assign accept    = req_valid && req_ready_q;
    assign rd_accept = accept && !req_we;
    assign in_range  = 32'(req_addr) < DEPTH;

    // ------------------------------------------------------------------
    // Controller FSM: clear counter and registered handshake outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= '0;
            req_ready_q <= 1'b0;
            init_busy_q <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (clr_cnt_q == LAST) begin
                        state_q     <= ST_READY;
                        clr_cnt_q   <= '0;
                        req_ready_q <= 1'b1;
                        init_busy_q <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    if (init_start) begin
                        state_q     <= ST_INIT;
                        clr_cnt_q   <= '0;
                        req_ready_q <= 1'b0;
                        init_busy_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign init_busy = init_busy_q;

    // ------------------------------------------------------------------
    // Array port mux: the clear sequencer owns the port while clearing;
    // no bus request can be accepted then because req_ready is low.
    // ------------------------------------------------------------------
    always_comb begin
        arr_we    = '0;
        arr_addr  = req_addr;
        arr_wdata = req_wdata;
        if (state_q == ST_INIT) begin
            arr_we    = '1;
            arr_addr  = clr_cnt_q;
            arr_wdata = INIT_VAL;
        end else if (accept && req_we && in_range) begin
            arr_we = req_be;
        end
    end

    sram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    assign rd_data_d = in_range ? arr_rdata : '0;

    // ------------------------------------------------------------------
    // Read pipeline. Data is snapshotted at the accept edge, so reads in
    // flight when a clear starts still return pre-clear contents. Data and
    // err only advance with a valid token, which keeps the output stage
    // holding the last response between pulses.
    // ------------------------------------------------------------------
    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] err_q;
    logic [DATA_W-1:0]     dat_q [RD_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_accept;
            if (rd_accept) begin
                err_q[0] <= !in_range;
                dat_q[0] <= rd_data_d;
            end
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    err_q[i] <= err_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign rsp_valid = vld_q[RD_LATENCY-1];
    assign rsp_err   = err_q[RD_LATENCY-1];
    assign rsp_rdata = dat_q[RD_LATENCY-1];

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// Self-checking bench for sram_sp_ctrl. Two instances (RD_LATENCY 1 and 2)
// share one stimulus stream; a memory-level model predicts every output.
module tb_sram_sp_ctrl;

    localparam int DEPTH = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        init_start = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = '0;

    logic [1:0]  rdy, rv, re, busy;
    logic [15:0] rd0, rd1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sram_sp_ctrl #(.DATA_W(16), .DEPTH(12), .RD_LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .init_start(init_start),
        .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv[0]), .rsp_rdata(rd0), .rsp_err(re[0]), .init_busy(busy[0])
    );

    sram_sp_ctrl #(.DATA_W(16), .DEPTH(12), .RD_LATENCY(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .init_start(init_start),
        .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv[1]), .rsp_rdata(rd1), .rsp_err(re[1]), .init_busy(busy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: memory contents, remaining clear words, and expected responses
    // (edge number at which each becomes visible, per latency).
    // ------------------------------------------------------------------
    typedef struct {
        int          due;
        logic [15:0] d;
        logic        e;
    } rsp_t;

    logic [15:0] m_mem [DEPTH];
    int          m_left = DEPTH;
    bit          m_ready = 1'b0;
    int          cyc = 0;
    rsp_t        mq [2][$];
    logic [15:0] m_last [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  = DEPTH;
            m_ready = 1'b0;
            cyc     = 0;
            mq[0].delete();
            mq[1].delete();
            m_last[0] = '0;
            m_last[1] = '0;
        end else begin
            cyc = cyc + 1;
            if (req_valid && m_ready) begin
                bit ok;
                ok = int'(req_addr) < DEPTH;
                if (req_we) begin
                    if (ok) begin
                        if (req_be[0]) m_mem[int'(req_addr)][7:0]  = req_wdata[7:0];
                        if (req_be[1]) m_mem[int'(req_addr)][15:8] = req_wdata[15:8];
                    end
                end else begin
                    rsp_t r;
                    r.d   = ok ? m_mem[int'(req_addr)] : 16'h0000;
                    r.e   = !ok;
                    r.due = cyc;
                    mq[0].push_back(r);
                    r.due = cyc + 1;
                    mq[1].push_back(r);
                end
            end
            if (m_left > 0) begin
                m_mem[DEPTH - m_left] = 16'h0000;
                m_left--;
                if (m_left == 0) m_ready = 1'b1;
            end else if (init_start) begin
                m_left  = DEPTH;
                m_ready = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                bit exp_v;
                exp_v = (mq[k].size() > 0) && (mq[k][0].due == cyc);
                chk($sformatf("m_ready[%0d]", k), rdy[k], m_ready);
                chk($sformatf("m_busy[%0d]", k), busy[k], !m_ready);
                chk($sformatf("m_valid[%0d]", k), rv[k], exp_v);
                if (exp_v) begin
                    m_last[k] = mq[k][0].d;
                    chk($sformatf("m_err[%0d]", k), re[k], mq[k][0].e);
                    void'(mq[k].pop_front());
                end
                chk($sformatf("m_rdata[%0d]", k), (k == 0) ? rd0 : rd1, m_last[k]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations.
    // ------------------------------------------------------------------
    task automatic issue(input logic we, input logic [3:0] a, input logic [15:0] d,
                         input logic [1:0] be, input logic st);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_wdata  = d;
        req_be     = be;
        init_start = st;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        init_start = 1'b0;
    endtask

    task automatic read_lit(input logic [3:0] a, input logic [15:0] d, input logic e);
        issue(1'b0, a, 16'h0000, 2'b00, 1'b0);
        @(negedge clk);
        chk($sformatf("rd_valid@%0d", a), rv[0], 1'b1);
        chk($sformatf("rd_data@%0d", a), rd0, d);
        chk($sformatf("rd_err@%0d", a), re[0], e);
    endtask

    // Counts negedges with req_ready low until it rises (bounded).
    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rdy[0]) break;
            n++;
        end
    endtask

    initial begin
        int n;
        logic [15:0] d1 [5];
        logic [15:0] d2 [5];
        logic        v1 [5];
        logic        v2 [5];

        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", rdy, 2'b00);
        chk("rst_busy", busy, 2'b11);
        chk("rst_valid", rv, 2'b00);
        chk("rst_rdata", {rd1, rd0}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready(n);
        chk("init_cycles", n, 12);

        for (int i = 0; i < DEPTH; i++) read_lit(4'(i), 16'h0000, 1'b0);

        issue(1'b1, 4'd3, 16'hA5C3, 2'b11, 1'b0);
        read_lit(4'd3, 16'hA5C3, 1'b0);
        issue(1'b1, 4'd3, 16'h1234, 2'b01, 1'b0);
        read_lit(4'd3, 16'hA534, 1'b0);
        issue(1'b1, 4'd3, 16'h5678, 2'b00, 1'b0);
        read_lit(4'd3, 16'hA534, 1'b0);

        read_lit(4'd12, 16'h0000, 1'b1);
        read_lit(4'd15, 16'h0000, 1'b1);
        issue(1'b1, 4'd13, 16'hFFFF, 2'b11, 1'b0);
        for (int i = 0; i < DEPTH; i++) read_lit(4'(i), (i == 3) ? 16'hA534 : 16'h0000, 1'b0);

        // Back-to-back reads: latency 1 responses in slots 0..2, latency 2 in 1..3.
        issue(1'b1, 4'd0, 16'h1111, 2'b11, 1'b0);
        issue(1'b1, 4'd1, 16'h2222, 2'b11, 1'b0);
        issue(1'b1, 4'd2, 16'h3333, 2'b11, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) issue(1'b0, 4'(i), 16'h0000, 2'b00, 1'b0);
            else begin
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            v1[i] = rv[0]; d1[i] = rd0;
            v2[i] = rv[1]; d2[i] = rd1;
        end
        chk("b2b_v1", {v1[0], v1[1], v1[2], v1[3], v1[4]}, 5'b11100);
        chk("b2b_v2", {v2[0], v2[1], v2[2], v2[3], v2[4]}, 5'b01110);
        chk("b2b_d1", {d1[0], d1[1]}, 32'h1111_2222);
        chk("b2b_d1_2", d1[2], 16'h3333);
        chk("b2b_d2", {d2[1], d2[2]}, 32'h1111_2222);
        chk("b2b_d2_3", d2[3], 16'h3333);

        // Clear started together with an accepted read.
        issue(1'b0, 4'd1, 16'h0000, 2'b00, 1'b1);
        @(negedge clk);
        chk("clr_old_valid", rv[0], 1'b1);
        chk("clr_old_data", rd0, 16'h2222);
        chk("clr_ready_drop", rdy[0], 1'b0);
        wait_ready(n);
        chk("clr_cycles", n + 1, 12);
        for (int i = 0; i < DEPTH; i++) read_lit(4'(i), 16'h0000, 1'b0);

        // Reset with reads in flight (clear also just started).
        issue(1'b1, 4'd5, 16'hBEEF, 2'b11, 1'b0);
        read_lit(4'd5, 16'hBEEF, 1'b0);
        issue(1'b0, 4'd5, 16'h0000, 2'b00, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstfl_valid", rv, 2'b00);
        chk("rstfl_ready", rdy, 2'b00);
        chk("rstfl_busy", busy, 2'b11);
        chk("rstfl_rdata", {rd1, rd0}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready(n);
        chk("rstfl_cycles", n, 12);

        // Reset in the middle of a clear.
        issue(1'b1, 4'd7, 16'hC0DE, 2'b11, 1'b0);
        init_start = 1'b1;
        @(posedge clk);
        #1 init_start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_busy", busy, 2'b11);
        chk("rstmid_ready", rdy, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready(n);
        chk("rstmid_cycles", n, 12);
        for (int i = 0; i < DEPTH; i++) read_lit(4'(i), 16'h0000, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
